transpose_buffer: RTL and testbench

TRANSPOSE_BUFFER -- requirements
Module: transpose_buffer

---
 rtl/transpose_buffer.sv | 186 ++++++++++++++++++
 tb/tb_transpose_buffer.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/transpose_buffer.sv
// Ping-pong transpose buffer between the row-pass and column-pass of an 8x8 DCT.
// Rows are written into one 8x8x12 bank while the other bank is read out
// column by column, with col_start pulses spaced COL_GAP cycles apart.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for rd_bank to become FULL
// EMIT  | one cycle: present column col_cnt of rd_bank, pulse col_start
// GAP   | spacing cycles between columns (and after the last column)
module transpose_buffer #(
   parameter int COL_GAP = 8
) (
   input  logic               sys_clk,
   input  logic               sys_rst_n,
   input  logic               row_valid,
   input  logic signed [11:0] row_z0,
   input  logic signed [11:0] row_z1,
   input  logic signed [11:0] row_z2,
   input  logic signed [11:0] row_z3,
   input  logic signed [11:0] row_z4,
   input  logic signed [11:0] row_z5,
   input  logic signed [11:0] row_z6,
   input  logic signed [11:0] row_z7,
   output logic               in_ready,
   output logic [95:0]        col_data,
   output logic               col_start,
   output logic [2:0]         col_idx,
   output logic               blk_done,
   output logic               overflow
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EMIT = 2'd1,
      GAP  = 2'd2
   } state_t;

   // GAP lasts COL_GAP-1 cycles; the counter runs down to zero from this value.
   localparam logic [3:0] GAP_LOAD = (COL_GAP > 1) ? 4'(COL_GAP - 2) : 4'd0;

   state_t      state;
   state_t      state_nxt;

   logic [11:0] mem [2][8][8];
   logic [11:0] row_z [8];
   logic [1:0]  bank_full;
   logic        wr_bank;
   logic        rd_bank;
   logic [2:0]  row_cnt;
   logic [2:0]  col_cnt;
   logic [3:0]  gap_cnt;
   logic        accept;
   logic        last_row;
   logic [95:0] col_column;
   logic [95:0] col_data_q;
   logic [2:0]  col_idx_q;

   assign row_z[0] = row_z0;
   assign row_z[1] = row_z1;
   assign row_z[2] = row_z2;
   assign row_z[3] = row_z3;
   assign row_z[4] = row_z4;
   assign row_z[5] = row_z5;
   assign row_z[6] = row_z6;
   assign row_z[7] = row_z7;

   assign in_ready = ~bank_full[wr_bank];
   assign accept   = row_valid & in_ready;
   assign last_row = accept & (row_cnt == 3'd7);

   // Bank storage: contents are never reset, only overwritten by accepted rows.
   always_ff @(posedge sys_clk) begin
      if (accept) begin
         for (int k = 0; k < 8; k++) begin
            mem[wr_bank][row_cnt][k] <= row_z[k];
         end
      end
   end

   // Write pointer, bank FULL/FREE flags and sticky overflow.
   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         row_cnt   <= 3'd0;
         wr_bank   <= 1'b0;
         bank_full <= 2'b00;
         overflow  <= 1'b0;
      end else begin
         if (accept) begin
            row_cnt <= row_cnt + 3'd1;
         end
         if (last_row) begin
            wr_bank            <= ~wr_bank;
            bank_full[wr_bank] <= 1'b1;
         end
         // Filling one bank and freeing the other can coincide; they never
         // address the same bank because a FULL bank refuses writes.
         if (blk_done) begin
            bank_full[rd_bank] <= 1'b0;
         end
         if (row_valid && !in_ready) begin
            overflow <= 1'b1;
         end
      end
   end

   // Read-side counters and the held copy of the last emitted column.
   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         rd_bank    <= 1'b0;
         col_cnt    <= 3'd0;
         gap_cnt    <= 4'd0;
         col_data_q <= 96'd0;
         col_idx_q  <= 3'd0;
      end else if (state == EMIT) begin
         col_cnt    <= col_cnt + 3'd1;
         gap_cnt    <= GAP_LOAD;
         col_data_q <= col_column;
         col_idx_q  <= col_cnt;
         if (col_cnt == 3'd7) begin
            rd_bank <= ~rd_bank;
         end
      end else if (state == GAP && gap_cnt != 4'd0) begin
         gap_cnt <= gap_cnt - 4'd1;
      end
   end

   // Column gather: lane r carries row r of the selected column.
   always_comb begin
      col_column = '0;
      for (int r = 0; r < 8; r++) begin
         col_column[12*r +: 12] = mem[rd_bank][r][col_cnt];
      end
   end

   // Read FSM state register.
   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Read FSM next state; col_cnt==0 outside EMIT means the block is finished.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (bank_full[rd_bank]) begin
               state_nxt = EMIT;
            end
         end
         EMIT: begin
            if (COL_GAP > 1) begin
               state_nxt = GAP;
            end else if (col_cnt == 3'd7) begin
               state_nxt = IDLE;
            end else begin
               state_nxt = EMIT;
            end
         end
         GAP: begin
            if (gap_cnt == 4'd0) begin
               state_nxt = (col_cnt != 3'd0) ? EMIT : IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Read FSM outputs; data and index hold their last emitted values between pulses.
   always_comb begin
      col_start = (state == EMIT);
      blk_done  = col_start && (col_cnt == 3'd7);
      col_data  = col_start ? col_column : col_data_q;
      col_idx   = col_start ? col_cnt    : col_idx_q;
   end

   // The bank still being read out must never be the one accepting rows.
   always_ff @(posedge sys_clk) begin
      if (sys_rst_n && accept && (state == EMIT || (state == GAP && col_cnt != 3'd0))) begin
         assert (wr_bank != rd_bank);
      end
   end

endmodule

// File: tb/tb_transpose_buffer.sv
// Bench for transpose_buffer: two instances (COL_GAP=8 and COL_GAP=1) share one
// stimulus stream. Each has its own reference model that predicts acceptance,
// in_ready, overflow and the exact cycle of every column pulse.
module tb_transpose_buffer;

   logic               sys_clk   = 1'b0;
   logic               sys_rst_n = 1'b0;
   logic               row_valid = 1'b0;
   logic signed [11:0] cur_row [8];

   logic        in_ready  [2];
   logic [95:0] col_data  [2];
   logic        col_start [2];
   logic [2:0]  col_idx   [2];
   logic        blk_done  [2];
   logic        overflow  [2];

   transpose_buffer #(.COL_GAP(8)) dut0 (
      .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .row_valid(row_valid),
      .row_z0(cur_row[0]), .row_z1(cur_row[1]), .row_z2(cur_row[2]), .row_z3(cur_row[3]),
      .row_z4(cur_row[4]), .row_z5(cur_row[5]), .row_z6(cur_row[6]), .row_z7(cur_row[7]),
      .in_ready(in_ready[0]), .col_data(col_data[0]), .col_start(col_start[0]),
      .col_idx(col_idx[0]), .blk_done(blk_done[0]), .overflow(overflow[0])
   );

   transpose_buffer #(.COL_GAP(1)) dut1 (
      .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .row_valid(row_valid),
      .row_z0(cur_row[0]), .row_z1(cur_row[1]), .row_z2(cur_row[2]), .row_z3(cur_row[3]),
      .row_z4(cur_row[4]), .row_z5(cur_row[5]), .row_z6(cur_row[6]), .row_z7(cur_row[7]),
      .in_ready(in_ready[1]), .col_data(col_data[1]), .col_start(col_start[1]),
      .col_idx(col_idx[1]), .blk_done(blk_done[1]), .overflow(overflow[1])
   );

   always #5 sys_clk = ~sys_clk;

   int cyc = 0;
   always @(posedge sys_clk) cyc <= cyc + 1;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   typedef struct {
      logic [95:0] data;
      logic [2:0]  idx;
      int          t;
   } col_t;

   col_t        sbq [2][$];
   int          gap_v     [2];
   int          free_at   [2][2];
   bit          mwr       [2];
   int          mrow      [2];
   int          last_done [2];
   int          last_start[2];
   bit          exp_ovf   [2];
   logic [11:0] mdata     [2][8][8];
   logic [95:0] last_data [2];
   logic [2:0]  last_idx  [2];
   bit          mon_en = 1'b0;

   function automatic bit mready(int u);
      return cyc >= free_at[u][mwr[u]];
   endfunction

   // A full bank turns into expected columns at the cycles the timing rules predict.
   task automatic complete_block(int u);
      int   st;
      col_t e;
      st = cyc + 2;
      if (last_done[u] + gap_v[u] + 1 > st) st = last_done[u] + gap_v[u] + 1;
      for (int c = 0; c < 8; c++) begin
         e.data = '0;
         for (int r = 0; r < 8; r++) e.data[12*r +: 12] = mdata[u][r][c];
         e.idx = 3'(c);
         e.t   = st + c * gap_v[u];
         sbq[u].push_back(e);
      end
      last_start[u]      = st;
      last_done[u]       = st + 7 * gap_v[u];
      free_at[u][mwr[u]] = last_done[u] + 1;
      mwr[u]             = ~mwr[u];
      mrow[u]            = 0;
   endtask

   task automatic step(input bit v);
      bit rdy;
      row_valid = v;
      for (int u = 0; u < 2; u++) begin
         rdy = mready(u);
         chk($sformatf("in_ready%0d", u), in_ready[u], rdy);
         chk($sformatf("overflow%0d", u), overflow[u], exp_ovf[u]);
         if (v) begin
            if (rdy) begin
               for (int k = 0; k < 8; k++) mdata[u][mrow[u]][k] = cur_row[k];
               mrow[u]++;
               if (mrow[u] == 8) complete_block(u);
            end else begin
               exp_ovf[u] = 1'b1;
            end
         end
      end
      @(posedge sys_clk);
      #1;
   endtask

   task automatic do_reset();
      sys_rst_n = 1'b0;
      row_valid = 1'b0;
      @(posedge sys_clk);
      #1;
      for (int u = 0; u < 2; u++) begin
         free_at[u][0] = 0;
         free_at[u][1] = 0;
         mwr[u]        = 1'b0;
         mrow[u]       = 0;
         last_done[u]  = -100;
         exp_ovf[u]    = 1'b0;
         last_data[u]  = '0;
         last_idx[u]   = '0;
         sbq[u].delete();
         chk($sformatf("rst_in_ready%0d", u), in_ready[u], 1);
         chk($sformatf("rst_col_start%0d", u), col_start[u], 0);
         chk($sformatf("rst_blk_done%0d", u), blk_done[u], 0);
         chk($sformatf("rst_overflow%0d", u), overflow[u], 0);
         chk($sformatf("rst_col_data%0d", u), col_data[u], 0);
         chk($sformatf("rst_col_idx%0d", u), col_idx[u], 0);
      end
      sys_rst_n = 1'b1;
   endtask

   task automatic send_row();
      for (int i = 0; i < 300 && !(mready(0) && mready(1)); i++) step(1'b0);
      step(1'b1);
   endtask

   task automatic drain();
      for (int i = 0; i < 400 && (sbq[0].size() != 0 || sbq[1].size() != 0); i++) step(1'b0);
      row_valid = 1'b0;
      chk("drain0", sbq[0].size(), 0);
      chk("drain1", sbq[1].size(), 0);
   endtask

   // Output monitor: column pulses against the scoreboard, held values otherwise.
   always @(negedge sys_clk) begin
      col_t e;
      if (mon_en) begin
         for (int u = 0; u < 2; u++) begin
            if (col_start[u]) begin
               if (sbq[u].size() == 0) begin
                  chk($sformatf("unexpected_col%0d", u), col_start[u], 0);
               end else begin
                  e = sbq[u].pop_front();
                  chk($sformatf("col_data%0d_c%0d", u, e.idx), col_data[u], e.data);
                  chk($sformatf("col_idx%0d", u), col_idx[u], e.idx);
                  chk($sformatf("col_time%0d_c%0d", u, e.idx), cyc, e.t);
                  chk($sformatf("blk_done%0d", u), blk_done[u], e.idx == 3'd7);
                  last_data[u] = e.data;
                  last_idx[u]  = e.idx;
               end
            end else begin
               chk($sformatf("hold_data%0d", u), col_data[u], last_data[u]);
               chk($sformatf("hold_idx%0d", u), col_idx[u], last_idx[u]);
               chk($sformatf("idle_blk_done%0d", u), blk_done[u], 0);
            end
         end
      end
   end

   initial begin
      int target;
      gap_v[0] = 8;
      gap_v[1] = 1;
      for (int k = 0; k < 8; k++) cur_row[k] = '0;
      repeat (2) @(posedge sys_clk);
      #1;
      do_reset();
      mon_en = 1'b1;

      // single block, element (r,k) = 16r+k
      for (int r = 0; r < 8; r++) begin
         for (int k = 0; k < 8; k++) cur_row[k] = 12'(16 * r + k);
         step(1'b1);
      end
      drain();

      // signed extremes alternate by row
      for (int r = 0; r < 8; r++) begin
         for (int k = 0; k < 8; k++) cur_row[k] = (r % 2 == 0) ? -12'sd2048 : 12'sd2047;
         step(1'b1);
      end
      drain();

      // ping-pong: 24 rows, offered as soon as both instances can take them
      for (int r = 0; r < 24; r++) begin
         for (int k = 0; k < 8; k++) cur_row[k] = 12'($urandom);
         send_row();
      end
      drain();

      // overflow: row_valid held high, rows dropped while the write bank is FULL
      for (int i = 0; i < 100; i++) begin
         for (int k = 0; k < 8; k++) cur_row[k] = 12'($urandom);
         step(1'b1);
      end
      drain();
      repeat (5) step(1'b0);
      do_reset();

      // reset while column 3 of the slower instance is on the output
      for (int r = 0; r < 8; r++) begin
         for (int k = 0; k < 8; k++) cur_row[k] = 12'($urandom);
         step(1'b1);
      end
      target = last_start[0] + 3 * gap_v[0];
      while (cyc < target) step(1'b0);
      do_reset();
      repeat (80) step(1'b0);
      for (int r = 0; r < 8; r++) begin
         for (int k = 0; k < 8; k++) cur_row[k] = 12'($urandom);
         step(1'b1);
      end
      drain();

      // 16 rows back-to-back: the COL_GAP=1 instance emits two blocks nearly bubble-free
      for (int r = 0; r < 16; r++) begin
         for (int k = 0; k < 8; k++) cur_row[k] = 12'($urandom);
         step(1'b1);
      end
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
